sum_serializer: RTL and testbench
=================================

SUM_SERIALIZER -- requirements
Module: sum_serializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1, byte order of the frame (1 = byte 0 is sum[7:0]; 0 = byte 0 is sum[31:24]).
REQ-002 Parameter: CHECKSUM, default 1, appends an XOR-of-data-bytes trailer byte when 1; frame is 4 bytes when 0.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sum  input  32  result word from the upstream 32-bit adder.
REQ-006 Port: sum_valid  input  1  sum is valid this cycle.
REQ-007 Port: sum_ready  output  1  block can capture sum this cycle.
REQ-008 Port: tx_data  output  8  current frame byte.
REQ-009 Port: tx_valid  output  1  tx_data is valid.
REQ-010 Port: tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-011 Port: tx_last  output  1  tx_data is the final byte of the frame.
REQ-012 Port: busy  output  1  a frame is in progress (state SEND).

Function
REQ-013 FSM states: IDLE, SEND; no other states.
REQ-014 IDLE: sum_ready = 1, tx_valid = 0, busy = 0.
REQ-015 IDLE -> SEND when sum_valid && sum_ready at a rising edge; sum captured into a 32-bit holding register, byte index cleared to 0, checksum register set to XOR of the four bytes of the captured sum.
REQ-016 Latency: capture at edge N; tx_valid = 1 with byte 0 from cycle N+1.
REQ-017 SEND: sum_ready = 0, tx_valid = 1, busy = 1; sum_valid ignored.
REQ-018 Byte transfer occurs on a rising edge with tx_valid && tx_ready; byte index increments by 1.
REQ-019 Hold: while tx_valid && !tx_ready, tx_data, tx_last and byte index remain unchanged.
REQ-020 Byte mapping, LSB_FIRST = 1: index k (0..3) -> sum[8k+7:8k]; LSB_FIRST = 0: index k -> sum[31-8k:24-8k].
REQ-021 CHECKSUM = 1: index 4 -> checksum byte; tx_last = 1 only at index 4.
REQ-022 CHECKSUM = 0: tx_last = 1 only at index 3.
REQ-023 Transfer of the tx_last byte -> IDLE on that edge; sum_ready = 1 the following cycle.
REQ-024 No overlap: a new sum cannot be captured in the same cycle as the final byte transfer; peak throughput is one frame per 6 cycles (CHECKSUM = 1) or 5 cycles (CHECKSUM = 0).
REQ-025 tx_data = 8'h00 and tx_last = 0 whenever tx_valid = 0.
REQ-026 The holding register is not modified while in SEND, regardless of sum or sum_valid activity.

Reset
REQ-027 reset high at a rising edge -> state IDLE, byte index 0, holding and checksum registers 0.
REQ-028 While reset is high: sum_ready = 0, tx_valid = 0, tx_last = 0, busy = 0, tx_data = 8'h00.
REQ-029 reset overrides all other inputs; asserting it mid-frame aborts the frame with no further bytes and no tx_last.
REQ-030 First cycle after reset deasserts: sum_ready = 1.

Verification
REQ-031 Basic: defaults, tx_ready = 1, sum = 32'h0003CCC0 pulsed once -> tx_data C0, CC, 03, 00, 0F on 5 consecutive cycles; tx_last only on 0F.
REQ-032 Order: LSB_FIRST = 0, sum = 32'h0003CCC0 -> bytes 00, 03, CC, C0, 0F; tx_last only on 0F.
REQ-033 Backpressure: sum = 32'h0000FFFF, tx_ready low for 3 cycles while byte 1 (FF) is presented -> tx_data holds FF for those cycles; frame completes FF, FF, 00, 00, 00.
REQ-034 Back-to-back: sum_valid held high, sum = 32'h00010000 presented during an active frame -> sum_ready stays 0 until one cycle after the prior tx_last transfer, then captures; bytes 00, 00, 01, 00, 01.
REQ-035 No checksum: CHECKSUM = 0, sum = 32'hFFFFFFFF -> exactly 4 bytes FF, tx_last on the 4th byte, IDLE on the next cycle.
REQ-036 Reset mid-frame: reset asserted for 1 cycle after byte 1 transfers -> tx_valid = 0 the next cycle; no tx_last; sum_ready = 1 one cycle after reset deasserts; the following frame starts at byte 0.

Source files
------------

// File: rtl/sum_serializer_if.sv
// Word-in / byte-out bundle of the sum serializer; master feeds sums and sinks bytes, slave is the serializer.
interface sum_serializer_if;
    logic [31:0] sum;
    logic        sum_valid;
    logic        sum_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;

    modport master (
        output sum, sum_valid, tx_ready,
        input  sum_ready, tx_data, tx_valid, tx_last, busy
    );

    modport slave (
        input  sum, sum_valid, tx_ready,
        output sum_ready, tx_data, tx_valid, tx_last, busy
    );
endinterface

// File: rtl/sum_serializer.sv
// Serializes a 32-bit sum into a 4-byte frame plus optional XOR trailer; first byte one cycle after capture.
// Bytes hold while tx_ready is low; no new sum is taken until the frame's last byte has gone.
module sum_serializer #(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit CHECKSUM  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sum_serializer_if.slave   bus
);
    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [2:0] LAST_IDX = CHECKSUM ? 3'd4 : 3'd3;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;

    logic [1:0]  lane;
    logic [7:0]  cur_byte;
    logic        sum_ready_d;
    logic        tx_valid_d;
    logic        tx_last_d;
    logic        busy_d;
    logic [7:0]  tx_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    // Index 4 only exists with the trailer enabled, where it selects the checksum.
    always_comb begin
        lane     = LSB_FIRST ? idx_q[1:0] : (2'd3 - idx_q[1:0]);
        cur_byte = (idx_q == 3'd4) ? csum_q : hold_q[{lane, 3'b000} +: 8];
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        sum_ready_d = 1'b0;
        tx_valid_d  = 1'b0;
        tx_last_d   = 1'b0;
        busy_d      = 1'b0;
        tx_data_d   = 8'h00;

        case (state_q)
            IDLE: begin
                sum_ready_d = 1'b1;
                if (bus.sum_valid) begin
                    state_d = SEND;
                    hold_d  = bus.sum;
                    idx_d   = 3'd0;
                    csum_d  = bus.sum[7:0] ^ bus.sum[15:8] ^ bus.sum[23:16] ^ bus.sum[31:24];
                end
            end
            SEND: begin
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
                tx_data_d  = cur_byte;
                tx_last_d  = (idx_q == LAST_IDX);
                if (bus.tx_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every output immediately, not just after the edge.
        if (reset) begin
            sum_ready_d = 1'b0;
            tx_valid_d  = 1'b0;
            tx_last_d   = 1'b0;
            busy_d      = 1'b0;
            tx_data_d   = 8'h00;
        end
    end

    assign bus.sum_ready = sum_ready_d;
    assign bus.tx_valid  = tx_valid_d;
    assign bus.tx_last   = tx_last_d;
    assign bus.busy      = busy_d;
    assign bus.tx_data   = tx_data_d;
endmodule

// File: tb/tb_sum_serializer.sv
module tb_sum_serializer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_in;
    logic        sv_in;
    logic        tr_in;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_serializer_if if0 ();
    sum_serializer_if if1 ();
    sum_serializer_if if2 ();

    assign if0.sum = s_in;  assign if0.sum_valid = sv_in;  assign if0.tx_ready = tr_in;
    assign if1.sum = s_in;  assign if1.sum_valid = sv_in;  assign if1.tx_ready = tr_in;
    assign if2.sum = s_in;  assign if2.sum_valid = sv_in;  assign if2.tx_ready = tr_in;

    sum_serializer #(.LSB_FIRST(1'b1), .CHECKSUM(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    sum_serializer #(.LSB_FIRST(1'b0), .CHECKSUM(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    sum_serializer #(.LSB_FIRST(1'b1), .CHECKSUM(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    logic       o_rdy [3];
    logic       o_vld [3];
    logic       o_last[3];
    logic       o_busy[3];
    logic [7:0] o_dat [3];

    assign o_rdy[0] = if0.sum_ready; assign o_vld[0] = if0.tx_valid; assign o_last[0] = if0.tx_last;
    assign o_busy[0] = if0.busy;     assign o_dat[0] = if0.tx_data;
    assign o_rdy[1] = if1.sum_ready; assign o_vld[1] = if1.tx_valid; assign o_last[1] = if1.tx_last;
    assign o_busy[1] = if1.busy;     assign o_dat[1] = if1.tx_data;
    assign o_rdy[2] = if2.sum_ready; assign o_vld[2] = if2.tx_valid; assign o_last[2] = if2.tx_last;
    assign o_busy[2] = if2.busy;     assign o_dat[2] = if2.tx_data;

    // Reference: each DUT owns a queue of bytes still to be sent in its current frame.
    localparam bit LSB_P[3] = '{1'b1, 1'b0, 1'b1};
    localparam bit CK_P [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] mq [3][$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic load_frame(input int i, input logic [31:0] s);
        logic [7:0] x;
        logic [7:0] b;
        int         sh;
        x = 8'h00;
        for (int k = 0; k < 4; k++) begin
            sh = LSB_P[i] ? 8 * k : 24 - 8 * k;
            b  = 8'(s >> sh);
            x  = x ^ b;
            mq[i].push_back(b);
        end
        if (CK_P[i]) mq[i].push_back(x);
    endtask

    task automatic step(input logic r, input logic sv, input logic [31:0] s, input logic tr);
        bit         busy_e;
        logic [7:0] dat_e;
        @(negedge clk);
        reset = r;
        sv_in = sv;
        s_in  = s;
        tr_in = tr;
        #1;
        for (int i = 0; i < 3; i++) begin
            busy_e = !r && (mq[i].size() > 0);
            dat_e  = busy_e ? mq[i][0] : 8'h00;
            check_val($sformatf("d%0d.sum_ready", i), 32'(o_rdy[i]),  32'(!r && mq[i].size() == 0));
            check_val($sformatf("d%0d.tx_valid", i),  32'(o_vld[i]),  32'(busy_e));
            check_val($sformatf("d%0d.busy", i),      32'(o_busy[i]), 32'(busy_e));
            check_val($sformatf("d%0d.tx_last", i),   32'(o_last[i]), 32'(busy_e && mq[i].size() == 1));
            check_val($sformatf("d%0d.tx_data", i),   32'(o_dat[i]),  32'(dat_e));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) mq[i].delete();
            else if (mq[i].size() == 0) begin
                if (sv) load_frame(i, s);
            end else if (tr) begin
                void'(mq[i].pop_front());
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        sv_in = 1'b0;
        s_in  = '0;
        tr_in = 1'b0;
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Single frame with the example word, downstream always ready.
        step(1'b0, 1'b1, 32'h0003CCC0, 1'b1);
        idle(7);

        // Backpressure: byte 0 goes, then three stalled cycles.
        step(1'b0, 1'b1, 32'h0000FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 1'b0);
        idle(6);

        // Back-to-back: valid held through two frames.
        step(1'b0, 1'b1, 32'h0003CCC0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 32'h00010000, 1'b1);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 32'h00010000, 1'b1);
        idle(7);

        step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        idle(7);

        // Reset after byte 1 has transferred, then a fresh frame.
        step(1'b0, 1'b1, 32'h12345678, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        step(1'b0, 1'b1, 32'hA5C30F81, 1'b1);
        idle(7);

        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(63) == 0), ($urandom_range(1) == 1), $urandom, ($urandom_range(9) < 7));
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
